pwm_update_sequencer: RTL and testbench
=======================================

PWM_UPDATE_SEQUENCER -- requirements
Module: pwm_update_sequencer

Interface
REQ-001 Parameter: width, 16, bit width of period, modulator and counter.
REQ-002 Parameter: period_rst, all ones (width bits), period driven after reset.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: enable  input  1  allows commits at carrier wrap; low freezes the sequencer.
REQ-006 Port: upd_valid  input  1  update request valid.
REQ-007 Port: upd_ready  output  1  sequencer can accept an update.
REQ-008 Port: upd_period  input  width  requested carrier period.
REQ-009 Port: upd_modulator  input  width  requested modulator (compare) value.
REQ-010 Port: ramp_step  input  width  modulator slew per carrier cycle; used only when the ramp feature is compiled in.
REQ-011 Port: counter  input  width  carrier counter from the PWM modulator.
REQ-012 Port: period  output  width  registered period to the PWM modulator.
REQ-013 Port: modulator  output  width  registered modulator to the PWM modulator.
REQ-014 Port: commit  output  1  one-cycle pulse when the final target values are applied.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 Wrap event SHALL be enable==1 and counter > period (the last carrier count before the counter returns to 0).
REQ-017 States SHALL be IDLE, PENDING and RAMP; upd_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, upd_valid&upd_ready SHALL capture both fields into shadow registers and move to PENDING.
REQ-019 A captured modulator greater than the captured period SHALL be clamped to period+1, saturating at all ones (0% duty).
REQ-020 In PENDING, a wrap event SHALL load period from the shadow register on that edge, so the new period is in effect when counter reads 0.
REQ-021 Without ramp, the same wrap event SHALL load modulator from the shadow register, pulse commit and return to IDLE.
REQ-022 With ramp, if the shadow modulator equals the current modulator, behaviour SHALL be as in REQ-021; otherwise the sequencer SHALL enter RAMP without changing modulator.
REQ-023 In RAMP, each wrap event SHALL move modulator toward the target by ramp_step, saturating exactly at the target.
REQ-024 In RAMP, ramp_step==0 SHALL be treated as 1.
REQ-025 In RAMP, the edge that reaches the target SHALL pulse commit and return to IDLE.
REQ-026 upd_valid on the same cycle as a wrap event in IDLE SHALL be accepted; its commit SHALL occur at the next wrap, not the current one.
REQ-027 enable==0 SHALL hold the state, shadow registers and outputs; acceptance in IDLE continues.
REQ-028 period and modulator SHALL change only on wrap events, never mid carrier cycle.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, period=period_rst, modulator=all ones, commit=0, busy=0, shadows=0.
REQ-030 rst asserted mid PENDING or mid RAMP SHALL discard the pending update with no commit pulse.

Configuration
REQ-031 Macro PWM_SEQ_RAMP_EN defined SHALL compile in the RAMP state and slew logic.
REQ-032 With PWM_SEQ_RAMP_EN undefined, RAMP SHALL be absent, ramp_step SHALL be ignored, and modulator SHALL step directly per REQ-021.

Structure
REQ-033 Package pwm_seq_pkg SHALL hold the state enum (IDLE, PENDING, RAMP) and the default width constant.
REQ-034 Sub-module pwm_ramp_step SHALL implement the combinational saturating step toward the target (up/down, zero-step fix).

Verification
REQ-035 Reset release with no update -> period=0xFFFF, modulator=0xFFFF, upd_ready=1, commit=0.
REQ-036 Update (period=99, modulator=50), no ramp -> upd_ready low until the edge where counter=100 and enable=1; then period=99, modulator=50 and a one-cycle commit.
REQ-037 Update modulator=150 with period=99 -> modulator commits as 100 (0% duty).
REQ-038 Ramp build, modulator 10->40, ramp_step=15 -> modulator 25 then 40 on consecutive wraps; commit only on 40.
REQ-039 enable=0 while PENDING for 3 carrier periods -> no change; first wrap after enable=1 commits.
REQ-040 rst pulse while RAMP -> immediate IDLE with reset outputs, no commit pulse.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM update sequencer.
// State encoding and default datapath width.
package pwm_seq_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    RAMP
  } seq_state_e;

endpackage

// File: rtl/pwm_ramp_step.sv
// One saturating slew step of the modulator toward its target.
// A zero step is promoted to one so a ramp always progresses.
module pwm_ramp_step #(
  parameter int unsigned width = 16
) (
  input  logic [width-1:0] cur_i,
  input  logic [width-1:0] tgt_i,
  input  logic [width-1:0] step_i,
  output logic [width-1:0] nxt_o
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] step_d;
  logic [width-1:0] gap_d;

  // Distance to target, then either land on it or move one step.
  always_comb begin
    step_d = (step_i == '0) ? ONE : step_i;
    if (tgt_i >= cur_i) begin
      gap_d = tgt_i - cur_i;
    end else begin
      gap_d = cur_i - tgt_i;
    end
    if (gap_d <= step_d) begin
      nxt_o = tgt_i;
    end else if (tgt_i > cur_i) begin
      nxt_o = cur_i + step_d;
    end else begin
      nxt_o = cur_i - step_d;
    end
  end

endmodule

// File: rtl/pwm_update_sequencer.sv
// Glitch-free period/modulator updates applied at carrier wrap.
// Define PWM_SEQ_RAMP_EN to compile in modulator slewing (RAMP).
module pwm_update_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned       width      = WIDTH_DEF,
  parameter logic [width-1:0]  period_rst = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [width-1:0] upd_period,
  input  logic [width-1:0] upd_modulator,
  input  logic [width-1:0] ramp_step,
  input  logic [width-1:0] counter,
  output logic [width-1:0] period,
  output logic [width-1:0] modulator,
  output logic             commit,
  output logic             busy
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  seq_state_e       state_q;
  logic [width-1:0] per_q;
  logic [width-1:0] mod_q;
  logic [width-1:0] sh_per_q;
  logic [width-1:0] sh_mod_q;
  logic             commit_q;
  logic             busy_q;
  logic             ready_q;

  logic             wrap_d;
  logic [width-1:0] cap_mod_d;
  logic             direct_d;

  // A full-scale period has no count above it, so the counter's
  // own rollover point marks the last carrier count instead.
  assign wrap_d = enable &&
                  ((counter > per_q) || (counter == '1));

  // Clamp an out-of-range compare to period+1 (0% duty).
  always_comb begin
    cap_mod_d = upd_modulator;
    if (upd_modulator > upd_period) begin
      cap_mod_d = (upd_period == '1) ? upd_period
                                     : upd_period + ONE;
    end
  end

`ifdef PWM_SEQ_RAMP_EN
  logic [width-1:0] mod_step_d;

  pwm_ramp_step #(
    .width (width)
  ) u_step (
    .cur_i  (mod_q),
    .tgt_i  (sh_mod_q),
    .step_i (ramp_step),
    .nxt_o  (mod_step_d)
  );

  assign direct_d = (sh_mod_q == mod_q);
`else
  logic unused_ramp_step;

  assign unused_ramp_step = ^ramp_step;
  assign direct_d         = 1'b1;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= period_rst;
      mod_q    <= '1;
      sh_per_q <= '0;
      sh_mod_q <= '0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (upd_valid) begin
            sh_per_q <= upd_period;
            sh_mod_q <= cap_mod_d;
            state_q  <= PENDING;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        PENDING: begin
          if (wrap_d) begin
            per_q <= sh_per_q;
            if (direct_d) begin
              mod_q    <= sh_mod_q;
              commit_q <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              state_q <= RAMP;
            end
          end
        end
`ifdef PWM_SEQ_RAMP_EN
        RAMP: begin
          if (wrap_d) begin
            mod_q <= mod_step_d;
            if (mod_step_d == sh_mod_q) begin
              commit_q <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign upd_ready = ready_q;
  assign period    = per_q;
  assign modulator = mod_q;
  assign commit    = commit_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Directed and randomized checks of pwm_update_sequencer
// against a behavioural model of the update rules.
module tb_pwm_update_sequencer;

  localparam logic [15:0] ALL1 = 16'hFFFF;
`ifdef PWM_SEQ_RAMP_EN
  localparam bit RAMP_BUILD = 1'b1;
`else
  localparam bit RAMP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_period;
  logic [15:0] upd_modulator;
  logic [15:0] ramp_step;
  logic [15:0] counter;
  logic [15:0] period;
  logic [15:0] modulator;
  logic        commit;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [15:0] m_per, m_mod, t_per, t_mod;
  bit          m_pend, m_ramp, m_commit;

  pwm_update_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_period    (upd_period),
    .upd_modulator (upd_modulator),
    .ramp_step     (ramp_step),
    .counter       (counter),
    .period        (period),
    .modulator     (modulator),
    .commit        (commit),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] clamp(input logic [15:0] m,
                                        input logic [15:0] p);
    if (m <= p) return m;
    if (p == ALL1) return ALL1;
    return p + 16'd1;
  endfunction

  task automatic model_reset();
    m_per = ALL1; m_mod = ALL1; t_per = '0; t_mod = '0;
    m_pend = 0; m_ramp = 0; m_commit = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".period"}, period, m_per);
    chk({tag, ".mod"}, modulator, m_mod);
    chk({tag, ".commit"}, {15'd0, commit}, {15'd0, m_commit});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, m_pend | m_ramp});
    chk({tag, ".ready"}, {15'd0, upd_ready},
        {15'd0, !(m_pend | m_ramp)});
  endtask

  // Apply one cycle of inputs, advance the model, then compare.
  task automatic cyc(input string tag, input bit v,
                     input logic [15:0] p, input logic [15:0] m,
                     input bit en, input logic [15:0] cnt,
                     input logic [15:0] st);
    bit wrap;
    int s, gap;
    upd_valid = v; upd_period = p; upd_modulator = m;
    enable = en; counter = cnt; ramp_step = st;
    wrap = en && (cnt > m_per || cnt == ALL1);
    m_commit = 0;
    if (!m_pend && !m_ramp) begin
      if (v) begin
        m_pend = 1; t_per = p; t_mod = clamp(m, p);
      end
    end else if (m_pend && wrap) begin
      m_per = t_per; m_pend = 0;
      if (!RAMP_BUILD || t_mod == m_mod) begin
        m_mod = t_mod; m_commit = 1;
      end else begin
        m_ramp = 1;
      end
    end else if (m_ramp && wrap) begin
      s = (st == 0) ? 1 : int'(st);
      gap = int'(t_mod) - int'(m_mod);
      if (gap < 0) gap = -gap;
      if (gap <= s) m_mod = t_mod;
      else if (t_mod > m_mod) m_mod = m_mod + 16'(s);
      else m_mod = m_mod - 16'(s);
      if (m_mod == t_mod) begin
        m_commit = 1; m_ramp = 0;
      end
    end
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, ".period"}, period, ALL1);
    chk({tag, ".mod"}, modulator, ALL1);
    chk({tag, ".ready"}, {15'd0, upd_ready}, 16'd1);
    chk({tag, ".commit"}, {15'd0, commit}, 16'd0);
    chk({tag, ".busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic [15:0] rc, rp, rm, lim;
    rst = 1'b1; enable = 1'b1; upd_valid = 1'b0;
    upd_period = '0; upd_modulator = '0;
    ramp_step = '0; counter = '0;
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("reset");

    // Establish a 99 period through a full-scale wrap.
    cyc("pre_acc", 1, 16'd99, 16'd10, 1, 16'd0, 16'd0);
    cyc("pre_nowrap", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    cyc("pre_wrap", 0, 16'd0, 16'd0, 1, ALL1, 16'd0);
    chk("pre.period", period, 16'd99);
    chk("pre.mod", modulator, 16'd10);

    // Basic update commits exactly at counter 100.
    cyc("b_acc", 1, 16'd99, 16'd50, 1, 16'd5, 16'd0);
    chk("b.ready_low", {15'd0, upd_ready}, 16'd0);
    cyc("b_99", 0, 16'd0, 16'd0, 1, 16'd99, 16'd0);
    chk("b.mod_hold", modulator, 16'd10);
    cyc("b_100", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    chk("b.mod", modulator, 16'd50);
    chk("b.commit", {15'd0, commit}, 16'd1);
    cyc("b_after", 0, 16'd0, 16'd0, 1, 16'd0, 16'd0);
    chk("b.commit_pulse", {15'd0, commit}, 16'd0);

    // Over-range compare clamps to period+1.
    cyc("c_acc", 1, 16'd99, 16'd150, 1, 16'd1, 16'd0);
    cyc("c_wrap", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    chk("c.mod", modulator, 16'd100);

    // Request on a wrap cycle commits at the following wrap.
    cyc("w_acc", 1, 16'd99, 16'd20, 1, 16'd100, 16'd0);
    chk("w.no_commit", {15'd0, commit}, 16'd0);
    cyc("w_mid", 0, 16'd0, 16'd0, 1, 16'd0, 16'd0);
    cyc("w_wrap", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    chk("w.mod", modulator, 16'd20);

    // Disabled carrier holds a pending update.
    cyc("e_acc", 1, 16'd99, 16'd30, 1, 16'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      cyc("e_off0", 0, 16'd0, 16'd0, 0, 16'd0, 16'd0);
      cyc("e_off50", 0, 16'd0, 16'd0, 0, 16'd50, 16'd0);
      cyc("e_off100", 0, 16'd0, 16'd0, 0, 16'd100, 16'd0);
    end
    chk("e.mod_hold", modulator, 16'd20);
    cyc("e_on", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    chk("e.mod", modulator, 16'd30);

`ifdef PWM_SEQ_RAMP_EN
    // Slew 30 -> 10, then 10 -> 40 in steps of 15.
    cyc("r_acc0", 1, 16'd99, 16'd10, 1, 16'd0, 16'd20);
    cyc("r_w0", 0, 16'd0, 16'd0, 1, 16'd100, 16'd20);
    cyc("r_w1", 0, 16'd0, 16'd0, 1, 16'd100, 16'd20);
    chk("r.mod10", modulator, 16'd10);
    cyc("r_acc", 1, 16'd99, 16'd40, 1, 16'd0, 16'd15);
    cyc("r_enter", 0, 16'd0, 16'd0, 1, 16'd100, 16'd15);
    chk("r.enter_mod", modulator, 16'd10);
    cyc("r_s1", 0, 16'd0, 16'd0, 1, 16'd100, 16'd15);
    chk("r.mod25", modulator, 16'd25);
    chk("r.no_commit", {15'd0, commit}, 16'd0);
    cyc("r_s2", 0, 16'd0, 16'd0, 1, 16'd100, 16'd15);
    chk("r.mod40", modulator, 16'd40);
    chk("r.commit", {15'd0, commit}, 16'd1);
    cyc("r_acc2", 1, 16'd99, 16'd90, 1, 16'd0, 16'd0);
    cyc("r_enter2", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    cyc("r_z1", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    chk("r.zero_step", modulator, 16'd41);
`else
    cyc("p_acc", 1, 16'd99, 16'd77, 1, 16'd0, 16'd0);
`endif

    // Asynchronous reset mid-update discards it.
    #3 rst = 1'b1;
    #1 check_reset_outs("async_rst");
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    cyc("post_rst0", 0, 16'd0, 16'd0, 1, 16'd100, 16'd0);
    cyc("post_rst1", 0, 16'd0, 16'd0, 1, ALL1, 16'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rp = 16'($urandom_range(0, 40));
      rm = 16'($urandom_range(0, 50));
      lim = (m_per > 16'd200) ? 16'd200 : m_per;
      if ($urandom_range(0, 3) == 0)
        rc = (m_per == ALL1) ? ALL1 : m_per + 16'd1;
      else
        rc = 16'($urandom_range(0, int'(lim)));
      cyc("rand", 1'($urandom_range(0, 1)), rp, rm,
          $urandom_range(0, 4) != 0, rc,
          16'($urandom_range(0, 8)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
